// File: rtl/mbuf_out_fifo.sv
// Byte-stream FIFO behind the mbuf1 inverting buffer chain: valid/ready capture,
// occupancy/full/empty status and a sticky overflow-attempt flag.
module mbuf_out_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    input  logic                     clr_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             push;
    logic             pop;

    // Handshake outputs depend on registered state only, never on in_*/out_ready.
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr];

    assign push = in_valid & ~full;
    assign pop  = ~empty & out_ready;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointers are AW bits wide, so DEPTH (a power of 2) wraps for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == CW'(0));
            // Set beats clear when both happen in one cycle.
            if (in_valid && full) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mbuf_out_fifo.sv
// Directed self-checking bench for mbuf_out_fifo (WIDTH=8, DEPTH=4).
module tb_mbuf_out_fifo;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       clr_ovf;

    int n_checks;
    int n_fail;

    mbuf_out_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; in_data = 8'h00;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count !== 3'd0)    begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++; if (full !== 1'b0)     begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
    endtask

    task automatic test_fill();
        logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = v[i];
            tick();
            n_checks++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
            n_checks++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_head[%0d] got %h/%b want 11/1", i, out_data, out_valid); end
        end
        in_valid = 1'b0;
        n_checks++; if (full !== 1'b1)     begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
    endtask

    task automatic test_drain();
        logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== v[i]) begin n_fail++; $display("FAIL drain[%0d] got %h/%b want %h/1", i, out_data, out_valid, v[i]); end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (empty !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL drain_empty got empty=%b out_valid=%b count=%0d want 1/0/0", empty, out_valid, count); end
    endtask

    task automatic test_push_pop();
        logic [7:0] v [3] = '{8'hA1, 8'hA2, 8'h55};
        in_valid = 1'b1; in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        in_data = 8'h55; out_ready = 1'b1;
        n_checks++; if (out_data !== 8'hA1) begin n_fail++; $display("FAIL pp_head got %h want a1", out_data); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL pp_count got %0d want 2", count); end
        for (int i = 1; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== v[i]) begin n_fail++; $display("FAIL pp_order[%0d] got %h want %h", i, out_data, v[i]); end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pp_empty got %b want 1", empty); end
    endtask

    task automatic test_stream();
        logic [7:0] q[$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit do_push;
        bit do_pop;
        while (got < 10 && cyc < 200) begin
            in_valid  = (sent < 10);
            in_data   = 8'(sent);
            out_ready = (cyc % 2 == 0);
            n_checks++; if (in_ready !== (q.size() < 4)) begin n_fail++; $display("FAIL stream_ready[%0d] got %b want %b", cyc, in_ready, q.size() < 4); end
            if (out_ready && q.size() > 0) begin
                n_checks++; if (out_data !== q[0]) begin n_fail++; $display("FAIL stream_data[%0d] got %h want %h", got, out_data, q[0]); end
            end
            tick();
            do_push = in_valid && (q.size() < 4);
            do_pop  = out_ready && (q.size() > 0);
            if (do_pop) begin void'(q.pop_front()); got++; end
            if (do_push) begin q.push_back(8'(sent)); sent++; end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (got != 10) begin n_fail++; $display("FAIL stream_total got %0d want 10", got); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty got %b want 1", empty); end
    endtask

    task automatic test_ovf();
        logic [7:0] v [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = v[i]; tick();
        end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_fill got %b want 0", ovf); end
        in_data = 8'hEE; tick();
        n_checks++; if (ovf !== 1'b1 || count !== 3'd4 || out_data !== 8'h61) begin n_fail++; $display("FAIL ovf_set got ovf=%b count=%0d data=%h want 1/4/61", ovf, count, out_data); end
        in_valid = 1'b0; tick();
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf); end
        clr_ovf = 1'b1; tick();
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", ovf); end
        in_valid = 1'b1; tick();
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b want 1", ovf); end
        clr_ovf = 1'b0; out_ready = 1'b1; tick();
        in_valid = 1'b0;
        n_checks++; if (count !== 3'd3 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_full_pop got count=%0d ovf=%b want 3/1", count, ovf); end
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== v[i]) begin n_fail++; $display("FAIL ovf_drain[%0d] got %h want %h", i, out_data, v[i]); end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_no_dup got empty=%b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h70 + i); tick();
        end
        in_data = 8'hEE; tick();
        in_data = 8'hEF; tick();
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ovf got %b want 1", ovf); end
        in_valid = 1'b0; out_ready = 1'b1; tick();
        in_valid = 1'b1; in_data = 8'h99;
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        n_checks++; if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset got count=%0d empty=%b out_valid=%b want 0/1/0", count, empty, out_valid); end
        n_checks++; if (ovf !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_ovf_data got ovf=%b data=%h want 0/00", ovf, out_data); end
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL mid_after got out_valid=%b count=%0d want 0/0", out_valid, count); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; clr_ovf = 1'b0;
        #2;
        test_reset();
        test_fill();
        test_drain();
        test_push_pop();
        test_stream();
        test_ovf();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
